// File: rtl/gate_sweep_if.sv
// Bundle between the gate sweep checker and its environment: GUT vector/output plus status.
// master = checker side, slave = environment/GUT side.
interface gate_sweep_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
);
    logic             start;
    logic [N_IN-1:0]  vec;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [N_IN-1:0]  first_err_vec;
    logic             first_err_vld;

    modport master (
        input  start, dut_out,
        output vec, busy, done, pass, err_count, first_err_vec, first_err_vld
    );

    modport slave (
        output start, dut_out,
        input  vec, busy, done, pass, err_count, first_err_vec, first_err_vld
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive input sweep of a combinational gate against a truth table.
// Optional macro GATE_SWEEP_STOP_ON_ERR_EN ends the sweep on the first mismatch.
module gate_sweep_checker #(
    parameter int                      N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b0110,
    parameter int                      SETTLE = 1,
    parameter int                      ERR_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    gate_sweep_if.master  bus
);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  fev_q, fev_d;
    logic             fvld_q, fvld_d;
    logic [SET_W-1:0] settle_q, settle_d;

    logic sample;
    logic mismatch;
    logic last_vec;
    logic finish;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign sample   = (state_q == S_RUN) && (settle_q == SET_W'(SETTLE - 1));
    assign mismatch = sample && (bus.dut_out != TRUTH[vec_q]);
    assign last_vec = (vec_q == {N_IN{1'b1}});
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
    assign finish   = sample && (last_vec || mismatch);
`else
    assign finish   = sample && last_vec;
`endif

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fvld_d   = fvld_q;
        settle_d = settle_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    vec_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    fev_d    = '0;
                    fvld_d   = 1'b0;
                    settle_d = '0;
                end
            end
            S_RUN: begin
                if (sample) begin
                    settle_d = '0;
                    if (mismatch) begin
                        err_d = sat_inc(err_q);
                        if (!fvld_q) begin
                            fev_d  = vec_q;
                            fvld_d = 1'b1;
                        end
                    end
                    // vec stays on the last driven vector once the sweep ends
                    if (finish) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_q == '0) && !mismatch;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fev_q    <= '0;
            fvld_q   <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fvld_q   <= fvld_d;
            settle_q <= settle_d;
        end
    end

    assign bus.vec           = vec_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_vec = fev_q;
    assign bus.first_err_vld = fvld_q;
endmodule
